// File: rtl/fetch_seq_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    ADV   = 3'd3,
    JUMP  = 3'd4,
    HALT  = 3'd5
  } fetch_state_t;

  localparam int DEFAULT_ADDR_W  = 16;
  localparam int DEFAULT_INSTR_W = 8;

endpackage

// File: rtl/fetch_timeout_timer.sv
// Counts consecutive enabled cycles; expired flags the ACK_TIMEOUT-th one.
// ACK_TIMEOUT = 0 disables the timer (expired stays low).
module fetch_timeout_timer #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (ACK_TIMEOUT > 0) begin : g_timer
      localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
      logic [CNT_W-1:0] count_reg;

      // count_reg holds the number of enabled cycles already elapsed
      assign expired = enable && (count_reg == CNT_W'(ACK_TIMEOUT - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= '0;
        end else if (enable && !expired) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end
    end else begin : g_no_timer
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC strobes, imem req/ack, decode valid/ready.
// Optional FETCH_PERF_CNT_EN adds a saturating stall_cnt output.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int INSTR_W     = DEFAULT_INSTR_W,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_req,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               halt_req,
  output logic               pc_load,
  output logic               pc_incr,
  output logic [ADDR_W-1:0]  pc_target,
  output logic               halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  output logic               fetch_err
);

  fetch_state_t state_reg;
  logic         expired;

  fetch_timeout_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_reg != FETCH),
    .enable (state_reg == FETCH),
    .expired(expired)
  );

  // Outputs are set alongside the transition so they hold for the whole next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_load     <= 1'b0;
      pc_incr     <= 1'b0;
      pc_target   <= '0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      pc_load <= 1'b0;
      pc_incr <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= FETCH;
            imem_req  <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            state_reg   <= ISSUE;
            imem_req    <= 1'b0;
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end else if (expired) begin
            state_reg <= HALT;
            imem_req  <= 1'b0;
            halted    <= 1'b1;
            fetch_err <= 1'b1;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (halt_req) begin
              state_reg <= HALT;
              halted    <= 1'b1;
            end else if (jump_req) begin
              state_reg <= JUMP;
              pc_load   <= 1'b1;
              pc_target <= jump_target;
            end else begin
              state_reg <= ADV;
              pc_incr   <= 1'b1;
            end
          end
        end
        ADV, JUMP: begin
          // PC strobe is this cycle; request starts once the PC has updated
          state_reg <= FETCH;
          imem_req  <= 1'b1;
        end
        HALT: begin
          if (start) begin
            state_reg <= ADV;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
            pc_incr   <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall;
  assign stall = ((state_reg == FETCH) && !imem_ack) ||
                 ((state_reg == ISSUE) && !instr_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state_reg == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
